// File: rtl/digits_to_word.sv
// rtl/digits_to_word.sv - serial decimal digit stream to binary word converter with saturation
module digits_to_word #(
    parameter int WIDTH     = 16,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       digit,
    input  logic             wen,
    input  logic             neg,
    input  logic             flush,
    output logic             ready,
    output logic [WIDTH-1:0] dout,
    output logic             ovf,
    output logic             err,
    output logic             empty
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        OVF   = 2'd2
    } state_t;

    // Extended width so mag*10+digit never wraps before the limit compare.
    localparam int XW = WIDTH + 5;
    localparam logic [XW-1:0] ONE_X = XW'(1);
    localparam logic [XW-1:0] LIM_U = (ONE_X << WIDTH) - ONE_X;
    localparam logic [XW-1:0] LIM_P = (ONE_X << (WIDTH - 1)) - ONE_X;
    localparam logic [XW-1:0] LIM_N = ONE_X << (WIDTH - 1);

    // Power-up values match the reset values so rst is optional after configuration.
    state_t           state     = IDLE;
    logic [WIDTH:0]   mag       = '0;
    logic             sign_q    = 1'b0;
    logic             err_q     = 1'b0;
    logic             has_digit = 1'b0;
    logic             ready_q   = 1'b0;
    logic [WIDTH-1:0] dout_q    = '0;
    logic             ovf_q     = 1'b0;
    logic             err_o_q   = 1'b0;
    logic             empty_q   = 1'b0;

    logic [XW-1:0]    limit;
    logic [XW-1:0]    next_mag;
    logic [WIDTH-1:0] sat_val;
    logic [WIDTH-1:0] conv_val;
    logic             digit_ok;

    assign ready = ready_q;
    assign dout  = dout_q;
    assign ovf   = ovf_q;
    assign err   = err_o_q;
    assign empty = empty_q;

    // Range limit, candidate magnitude and the two possible published values.
    always_comb begin
        limit = LIM_U;
        if (SIGNED_EN) begin
            limit = sign_q ? LIM_N : LIM_P;
        end
        next_mag = ({4'b0000, mag} << 3) + ({4'b0000, mag} << 1)
                 + {{(XW-4){1'b0}}, digit};
        digit_ok = (digit <= 4'd9);
        sat_val  = '1;
        if (SIGNED_EN) begin
            sat_val = sign_q ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
        conv_val = WIDTH'(sign_q ? (~mag + 1'b1) : mag);
    end

    // Accumulator FSM and registered publish on flush; flush outranks wen/neg.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            mag       <= '0;
            sign_q    <= 1'b0;
            err_q     <= 1'b0;
            has_digit <= 1'b0;
            ready_q   <= 1'b0;
            dout_q    <= '0;
            ovf_q     <= 1'b0;
            err_o_q   <= 1'b0;
            empty_q   <= 1'b0;
        end else begin
            ready_q <= flush;
            if (flush) begin
                if (state == OVF) begin
                    dout_q <= sat_val;
                end else if (!has_digit) begin
                    dout_q <= '0;
                end else begin
                    dout_q <= conv_val;
                end
                ovf_q     <= (state == OVF);
                err_o_q   <= err_q;
                empty_q   <= !has_digit;
                state     <= IDLE;
                mag       <= '0;
                sign_q    <= 1'b0;
                err_q     <= 1'b0;
                has_digit <= 1'b0;
            end else if (wen && neg) begin
                err_q <= 1'b1;
            end else if (wen) begin
                if (!digit_ok) begin
                    err_q <= 1'b1;
                end else if (state != OVF) begin
                    // An overflowing digit still counts as a digit: the number is not empty.
                    has_digit <= 1'b1;
                    if (next_mag <= limit) begin
                        mag   <= next_mag[WIDTH:0];
                        state <= ACCUM;
                    end else begin
                        state <= OVF;
                    end
                end
            end else if (neg) begin
                if (SIGNED_EN && state == IDLE) begin
                    sign_q <= 1'b1;
                    state  <= ACCUM;
                end else begin
                    err_q <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_digits_to_word.sv
// tb/tb_digits_to_word.sv - scoreboard bench for digits_to_word, signed and unsigned instances
module tb_digits_to_word;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  digit_s = '0, digit_u = '0;
    logic        wen_s = 0, neg_s = 0, flush_s = 0;
    logic        wen_u = 0, neg_u = 0, flush_u = 0;
    logic        ready_s, ovf_s, err_s, empty_s;
    logic        ready_u, ovf_u, err_u, empty_u;
    logic [15:0] dout_s, dout_u;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [15:0] d;
        logic        o;
        logic        e;
        logic        m;
    } exp_t;

    exp_t q_s[$];
    exp_t q_u[$];

    always #5 clk = ~clk;

    digits_to_word #(.WIDTH(16), .SIGNED_EN(1'b1)) u_dut_s (
        .clk(clk), .rst(rst), .digit(digit_s), .wen(wen_s), .neg(neg_s), .flush(flush_s),
        .ready(ready_s), .dout(dout_s), .ovf(ovf_s), .err(err_s), .empty(empty_s)
    );

    digits_to_word #(.WIDTH(16), .SIGNED_EN(1'b0)) u_dut_u (
        .clk(clk), .rst(rst), .digit(digit_u), .wen(wen_u), .neg(neg_u), .flush(flush_u),
        .ready(ready_u), .dout(dout_u), .ovf(ovf_u), .err(err_u), .empty(empty_u)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cs(input logic w, input logic [3:0] d, input logic n, input logic f, input logic r);
        wen_s = w; digit_s = d; neg_s = n; flush_s = f; rst = r;
        @(posedge clk);
        #1;
        wen_s = 0; digit_s = 0; neg_s = 0; flush_s = 0; rst = 0;
    endtask

    task automatic cu(input logic w, input logic [3:0] d, input logic n, input logic f);
        wen_u = w; digit_u = d; neg_u = n; flush_u = f;
        @(posedge clk);
        #1;
        wen_u = 0; digit_u = 0; neg_u = 0; flush_u = 0;
    endtask

    task automatic exp_s(input logic [15:0] d, input logic o, input logic e, input logic m);
        q_s.push_back('{d: d, o: o, e: e, m: m});
    endtask

    task automatic exp_u(input logic [15:0] d, input logic o, input logic e, input logic m);
        q_u.push_back('{d: d, o: o, e: e, m: m});
    endtask

    // Signed-instance monitor
    always @(negedge clk) begin
        if (ready_s) begin
            if (q_s.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL s_unexpected_ready: got ready=1 expected no pulse");
            end else begin
                exp_t e;
                e = q_s.pop_front();
                chk("s_dout", 32'(dout_s), 32'(e.d));
                chk("s_ovf", 32'(ovf_s), 32'(e.o));
                chk("s_err", 32'(err_s), 32'(e.e));
                chk("s_empty", 32'(empty_s), 32'(e.m));
            end
        end
    end

    // Unsigned-instance monitor
    always @(negedge clk) begin
        if (ready_u) begin
            if (q_u.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL u_unexpected_ready: got ready=1 expected no pulse");
            end else begin
                exp_t e;
                e = q_u.pop_front();
                chk("u_dout", 32'(dout_u), 32'(e.d));
                chk("u_ovf", 32'(ovf_u), 32'(e.o));
                chk("u_err", 32'(err_u), 32'(e.e));
                chk("u_empty", 32'(empty_u), 32'(e.m));
            end
        end
    end

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(ready_s), 0);
        chk("rst_dout", 32'(dout_s), 0);
        chk("rst_ovf", 32'(ovf_s), 0);
        chk("rst_err", 32'(err_s), 0);
        chk("rst_empty", 32'(empty_s), 0);
        rst = 1'b0;
        cs(0, 0, 0, 0, 0);

        // 1,2,3 -> 123
        cs(1, 1, 0, 0, 0); cs(1, 2, 0, 0, 0); cs(1, 3, 0, 0, 0);
        exp_s(16'h007B, 0, 0, 0); cs(0, 0, 0, 1, 0);

        // -32768 fits exactly
        cs(0, 0, 1, 0, 0);
        cs(1, 3, 0, 0, 0); cs(1, 2, 0, 0, 0); cs(1, 7, 0, 0, 0); cs(1, 6, 0, 0, 0); cs(1, 8, 0, 0, 0);
        exp_s(16'h8000, 0, 0, 0); cs(0, 0, 0, 1, 0);

        // +32768 saturates
        cs(1, 3, 0, 0, 0); cs(1, 2, 0, 0, 0); cs(1, 7, 0, 0, 0); cs(1, 6, 0, 0, 0); cs(1, 8, 0, 0, 0);
        exp_s(16'h7FFF, 1, 0, 0); cs(0, 0, 0, 1, 0);

        // illegal digit ignored but flagged
        cs(1, 4, 0, 0, 0); cs(1, 4'hB, 0, 0, 0); cs(1, 2, 0, 0, 0);
        exp_s(16'd42, 0, 1, 0); cs(0, 0, 0, 1, 0);

        // sign after digit
        cs(1, 4, 0, 0, 0); cs(0, 0, 1, 0, 0);
        exp_s(16'd4, 0, 1, 0); cs(0, 0, 0, 1, 0);

        // back-to-back flush
        cs(1, 7, 0, 0, 0);
        exp_s(16'd7, 0, 0, 0); cs(0, 0, 0, 1, 0);
        exp_s(16'd0, 0, 0, 1); cs(0, 0, 0, 1, 0);

        // flush wins over coincident digit; digits accepted during ready; leading zeros
        cs(1, 5, 0, 0, 0);
        exp_s(16'd5, 0, 0, 0); cs(1, 9, 0, 1, 0);
        for (int i = 0; i < 6; i++) cs(1, 0, 0, 0, 0);
        cs(1, 1, 0, 0, 0);
        exp_s(16'd1, 0, 0, 0); cs(0, 0, 0, 1, 0);

        // reset mid-number, with a flush under reset that must not pulse
        cs(1, 1, 0, 0, 0); cs(1, 2, 0, 0, 0);
        cs(0, 0, 0, 1, 1);
        cs(1, 3, 0, 0, 0);
        exp_s(16'd3, 0, 0, 0); cs(0, 0, 0, 1, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("hold_dout", 32'(dout_s), 3);
        chk("hold_ready", 32'(ready_s), 0);

        // wen and neg together: both discarded, error set
        cs(1, 5, 0, 0, 0); cs(1, 6, 1, 0, 0);
        exp_s(16'd5, 0, 1, 0); cs(0, 0, 0, 1, 0);

        // lone sign is an empty number
        cs(0, 0, 1, 0, 0);
        exp_s(16'd0, 0, 0, 1); cs(0, 0, 0, 1, 0);

        // unsigned instance: 65536 saturates, 65535 fits, sign is an error
        cu(1, 6, 0, 0); cu(1, 5, 0, 0); cu(1, 5, 0, 0); cu(1, 3, 0, 0); cu(1, 6, 0, 0);
        exp_u(16'hFFFF, 1, 0, 0); cu(0, 0, 0, 1);
        cu(1, 6, 0, 0); cu(1, 5, 0, 0); cu(1, 5, 0, 0); cu(1, 3, 0, 0); cu(1, 5, 0, 0);
        exp_u(16'hFFFF, 0, 0, 0); cu(0, 0, 0, 1);
        cu(0, 0, 1, 0); cu(1, 2, 0, 0);
        exp_u(16'd2, 0, 1, 0); cu(0, 0, 0, 1);

        repeat (5) @(posedge clk);
        #1;
        chk("s_pending", 32'(q_s.size()), 0);
        chk("u_pending", 32'(q_u.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
